// File: rtl/dsp_pack.sv
// dsp_pack: packs 4-word DSP bursts (ch1, ch2, ch3, marker) into 6-word
// timestamped 32-bit frames and queues them in a first-word-fall-through
// word FIFO. The FIFO feeds a valid/ready stream toward the host interface.
// Optional feature macro: DSP_PACK_STAT_EN.
// - When defined, the stat_drop and stat_trunc counters are built.
// - When undefined, both outputs are tied to zero.
//
// Writer FSM
//   state  | meaning
//   W_IDLE | no frame being written
//   W_HDR  | pushing W0 {SYNC, seq, flags, 8'h06}
//   W_UTC  | pushing W1 utc
//   W_NS   | pushing W2 ns
//   W_CH1  | pushing W3 {8'h01, ch1}
//   W_CH2  | pushing W4 {8'h02, ch2}
//   W_CH3  | pushing W5 {8'h03, ch3}; a new frame may be accepted here
module dsp_pack #(
    parameter int          FIFO_AW = 6,
    parameter logic [23:0] MARKER  = 24'h004444,
    parameter logic [7:0]  SYNC    = 8'hA5
) (
    input  logic               clk_sys,
    input  logic               rst,
    input  logic [23:0]        dp_data,
    input  logic               dp_vld,
    input  logic [31:0]        dp_utc,
    input  logic [31:0]        dp_ns,
    output logic [31:0]        pk_data,
    output logic               pk_vld,
    input  logic               pk_rdy,
    output logic               pk_sof,
    output logic               pk_eof,
    output logic [FIFO_AW:0]   fifo_level,
    output logic [15:0]        stat_drop,
    output logic [15:0]        stat_trunc
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW+1:0] DEPTH_W = (FIFO_AW+2)'(1) << FIFO_AW;
    localparam logic [FIFO_AW+1:0] FRAME_W = (FIFO_AW+2)'(6);

    typedef enum logic [2:0] {
        W_IDLE, W_HDR, W_UTC, W_NS, W_CH1, W_CH2, W_CH3
    } wst_t;

    logic [1:0]  r_idx;
    logic [31:0] r_cap_utc, r_cap_ns;
    logic [23:0] r_cap_ch1, r_cap_ch2, r_cap_ch3;
    logic [7:0]  r_seq;

    wst_t        r_wst;
    logic [7:0]  r_frm_seq;
    logic        r_frm_mis;
    logic [31:0] r_frm_utc, r_frm_ns;
    logic [23:0] r_frm_ch1, r_frm_ch2, r_frm_ch3;

    logic [33:0]      r_mem [DEPTH];
    logic [FIFO_AW:0] r_wr_ptr, r_rd_ptr;

    logic             w_commit, w_accept, w_writer_free, w_space_ok;
    logic             w_push, w_pop, w_empty, w_full;
    logic [FIFO_AW:0] w_level;
    logic [FIFO_AW+1:0] w_free;
    logic [33:0]      w_wr_word, w_rd_word;

    assign w_commit      = dp_vld && (r_idx == 2'd3);
    // The last writer cycle hands over directly to the next frame, so a
    // legal 6-cycle burst period never collides with the writer.
    assign w_writer_free = (r_wst == W_IDLE) || (r_wst == W_CH3);
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                      (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
    assign w_level  = r_wr_ptr - r_rd_ptr;
    assign w_push   = (r_wst != W_IDLE) && !w_full;
    assign w_pop    = !w_empty && pk_rdy;
    // The word the writer pushes this cycle also consumes space. Counting it
    // guarantees that an accepted frame always fits completely.
    assign w_free     = DEPTH_W - {1'b0, w_level} - {{(FIFO_AW+1){1'b0}}, w_push};
    assign w_space_ok = (w_free >= FRAME_W);
    assign w_accept   = w_commit && w_writer_free && w_space_ok;

    // Burst capture: index consecutive valid words and latch their fields.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_idx     <= '0;
            r_cap_utc <= '0;
            r_cap_ns  <= '0;
            r_cap_ch1 <= '0;
            r_cap_ch2 <= '0;
            r_cap_ch3 <= '0;
        end else if (dp_vld) begin
            case (r_idx)
                2'd0: begin
                    r_cap_utc <= dp_utc;
                    r_cap_ns  <= dp_ns;
                    r_cap_ch1 <= dp_data;
                end
                2'd1:    r_cap_ch2 <= dp_data;
                2'd2:    r_cap_ch3 <= dp_data;
                default: ;
            endcase
            r_idx <= r_idx + 2'd1;
        end else begin
            r_idx <= '0;
        end
    end

    // Sequence number advances on every commit, accepted or dropped.
    always_ff @(posedge clk_sys) begin
        if (rst)           r_seq <= '0;
        else if (w_commit) r_seq <= r_seq + 8'd1;
    end

    // Writer FSM: load the frame registers on accept, then push six words.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_wst     <= W_IDLE;
            r_frm_seq <= '0;
            r_frm_mis <= 1'b0;
            r_frm_utc <= '0;
            r_frm_ns  <= '0;
            r_frm_ch1 <= '0;
            r_frm_ch2 <= '0;
            r_frm_ch3 <= '0;
        end else if (w_accept) begin
            r_wst     <= W_HDR;
            r_frm_seq <= r_seq;
            r_frm_mis <= (dp_data != MARKER);
            r_frm_utc <= r_cap_utc;
            r_frm_ns  <= r_cap_ns;
            r_frm_ch1 <= r_cap_ch1;
            r_frm_ch2 <= r_cap_ch2;
            r_frm_ch3 <= r_cap_ch3;
        end else begin
            case (r_wst)
                W_HDR:   r_wst <= W_UTC;
                W_UTC:   r_wst <= W_NS;
                W_NS:    r_wst <= W_CH1;
                W_CH1:   r_wst <= W_CH2;
                W_CH2:   r_wst <= W_CH3;
                default: r_wst <= W_IDLE;
            endcase
        end
    end

    // Select the FIFO entry {sof, eof, data} for the current writer state.
    always_comb begin
        w_wr_word = '0;
        case (r_wst)
            W_HDR:   w_wr_word = {2'b10, SYNC, r_frm_seq, 7'd0, r_frm_mis, 8'h06};
            W_UTC:   w_wr_word = {2'b00, r_frm_utc};
            W_NS:    w_wr_word = {2'b00, r_frm_ns};
            W_CH1:   w_wr_word = {2'b00, 8'h01, r_frm_ch1};
            W_CH2:   w_wr_word = {2'b00, 8'h02, r_frm_ch2};
            W_CH3:   w_wr_word = {2'b01, 8'h03, r_frm_ch3};
            default: w_wr_word = '0;
        endcase
    end

    // FIFO storage: contents need no reset because the pointers define validity.
    always_ff @(posedge clk_sys) begin
        if (w_push) r_mem[r_wr_ptr[FIFO_AW-1:0]] <= w_wr_word;
    end

    // FIFO pointers; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    assign w_rd_word  = r_mem[r_rd_ptr[FIFO_AW-1:0]];
    assign pk_vld     = !w_empty;
    assign pk_data    = pk_vld ? w_rd_word[31:0] : '0;
    assign pk_sof     = pk_vld & w_rd_word[33];
    assign pk_eof     = pk_vld & w_rd_word[32];
    assign fifo_level = w_level;

`ifdef DSP_PACK_STAT_EN
    logic        w_drop, w_trunc;
    logic [15:0] r_stat_drop, r_stat_trunc;

    assign w_drop  = w_commit && !w_accept;
    assign w_trunc = !dp_vld && (r_idx != 2'd0);

    // Saturating drop/truncation counters.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_stat_drop  <= '0;
            r_stat_trunc <= '0;
        end else begin
            if (w_drop && (r_stat_drop != 16'hFFFF))
                r_stat_drop <= r_stat_drop + 16'd1;
            if (w_trunc && (r_stat_trunc != 16'hFFFF))
                r_stat_trunc <= r_stat_trunc + 16'd1;
        end
    end

    assign stat_drop  = r_stat_drop;
    assign stat_trunc = r_stat_trunc;
`else
    assign stat_drop  = 16'h0;
    assign stat_trunc = 16'h0;
`endif

endmodule

// File: tb/tb_dsp_pack.sv
// Testbench for dsp_pack.
// - The design is instantiated with FIFO_AW=3, giving an 8-word FIFO.
// - A queue-based reference model tracks three things: the pending writer
//   words, the FIFO contents and the statistics.
// - Directed scenarios are followed by a randomized burst stream.
module tb_dsp_pack;

    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;

    logic        clk_sys = 1'b0;
    logic        rst     = 1'b1;
    logic [23:0] dp_data = '0;
    logic        dp_vld  = 1'b0;
    logic [31:0] dp_utc  = '0;
    logic [31:0] dp_ns   = '0;
    logic [31:0] pk_data;
    logic        pk_vld;
    logic        pk_rdy  = 1'b0;
    logic        pk_sof, pk_eof;
    logic [AW:0] fifo_level;
    logic [15:0] stat_drop, stat_trunc;

    dsp_pack #(.FIFO_AW(AW)) dut (
        .clk_sys   (clk_sys),
        .rst       (rst),
        .dp_data   (dp_data),
        .dp_vld    (dp_vld),
        .dp_utc    (dp_utc),
        .dp_ns     (dp_ns),
        .pk_data   (pk_data),
        .pk_vld    (pk_vld),
        .pk_rdy    (pk_rdy),
        .pk_sof    (pk_sof),
        .pk_eof    (pk_eof),
        .fifo_level(fifo_level),
        .stat_drop (stat_drop),
        .stat_trunc(stat_trunc)
    );

    always #5 clk_sys = ~clk_sys;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    logic [33:0] m_q[$];
    logic [33:0] m_pend[$];
    logic [23:0] m_burst[$];
    logic [31:0] m_butc, m_bns;
    logic [7:0]  m_seq;
    int          m_drop, m_trunc;
    bit          m_known = 0;
    bit          m_after_rst = 0;
    bit          tog_mode = 0;
    logic [31:0] m_log[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int stat_exp(input int v);
`ifdef DSP_PACK_STAT_EN
        return (v > 65535) ? 65535 : v;
`else
        return 0 * v;
`endif
    endfunction

    task automatic model_update();
        bit pop, commit;
        int busy_before, words_before, free;
        logic [23:0] c1, c2, c3, mk;
        if (rst) begin
            m_q.delete(); m_pend.delete(); m_burst.delete();
            m_seq = 0; m_drop = 0; m_trunc = 0;
            m_known = 1; m_after_rst = 1;
            return;
        end
        m_after_rst  = 0;
        pop          = (m_q.size() > 0) && pk_rdy;
        busy_before  = m_pend.size();
        words_before = m_q.size();
        commit       = 0;
        if (dp_vld) begin
            if (m_burst.size() == 0) begin
                m_butc = dp_utc;
                m_bns  = dp_ns;
            end
            m_burst.push_back(dp_data);
            if (m_burst.size() == 4) commit = 1;
        end else if (m_burst.size() > 0) begin
            m_trunc++;
            m_burst.delete();
        end
        if (pop) void'(m_q.pop_front());
        if (busy_before > 0) m_q.push_back(m_pend.pop_front());
        if (commit) begin
            free = DEPTH - words_before - ((busy_before > 0) ? 1 : 0);
            if (busy_before <= 1 && free >= 6) begin
                c1 = m_burst[0]; c2 = m_burst[1]; c3 = m_burst[2]; mk = m_burst[3];
                m_pend.push_back({2'b10, 8'hA5, m_seq, 7'd0, (mk != 24'h004444), 8'h06});
                m_pend.push_back({2'b00, m_butc});
                m_pend.push_back({2'b00, m_bns});
                m_pend.push_back({2'b00, 8'h01, c1});
                m_pend.push_back({2'b00, 8'h02, c2});
                m_pend.push_back({2'b01, 8'h03, c3});
            end else begin
                m_drop++;
            end
            m_seq = m_seq + 8'd1;
            m_burst.delete();
        end
    endtask

    // One clock: check outputs at the falling edge, advance the model, then
    // let the caller drive new inputs just after the rising edge.
    task automatic step();
        bit ev;
        @(negedge clk_sys);
        if (m_known) begin
            ev = (m_q.size() > 0);
            check("pk_vld", 64'(pk_vld), 64'(ev));
            if (ev) begin
                check("pk_data", 64'(pk_data), 64'(m_q[0][31:0]));
                check("pk_sof", 64'(pk_sof), 64'(m_q[0][33]));
                check("pk_eof", 64'(pk_eof), 64'(m_q[0][32]));
                if (pk_vld && pk_rdy) m_log.push_back(pk_data);
            end else if (m_after_rst) begin
                check("pk_data_rst", 64'(pk_data), 64'd0);
                check("pk_sof_rst", 64'(pk_sof), 64'd0);
                check("pk_eof_rst", 64'(pk_eof), 64'd0);
            end
            check("fifo_level", 64'(fifo_level), 64'(m_q.size()));
            check("stat_drop", 64'(stat_drop), 64'(stat_exp(m_drop)));
            check("stat_trunc", 64'(stat_trunc), 64'(stat_exp(m_trunc)));
        end
        model_update();
        @(posedge clk_sys);
        #1;
        if (tog_mode) pk_rdy = ~pk_rdy;
    endtask

    task automatic idle(input int n);
        dp_vld = 0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic burst(input logic [31:0] utc, input logic [31:0] ns,
                         input logic [23:0] c1, input logic [23:0] c2,
                         input logic [23:0] c3, input logic [23:0] mk, input int gap);
        logic [23:0] w[4];
        w[0] = c1; w[1] = c2; w[2] = c3; w[3] = mk;
        dp_utc = utc;
        dp_ns  = ns;
        for (int i = 0; i < 4; i++) begin
            dp_vld  = 1;
            dp_data = w[i];
            step();
        end
        idle(gap);
    endtask

    task automatic do_reset();
        rst = 1; dp_vld = 0;
        step();
        rst = 0;
        m_log.delete();
    endtask

    initial begin
        logic [31:0] r1, r2;
        int len;

        pk_rdy = 1;
        step();
        do_reset();
        idle(2);

        // single burst with the nominal marker
        burst(32'h12345678, 32'd500, 24'h000111, 24'h000222, 24'h000333, 24'h004444, 10);
        check("t1_count", 64'(m_log.size()), 64'd6);
        if (m_log.size() == 6) begin
            check("t1_w0", 64'(m_log[0]), 64'hA5000006);
            check("t1_w1", 64'(m_log[1]), 64'h12345678);
            check("t1_w2", 64'(m_log[2]), 64'h000001F4);
            check("t1_w3", 64'(m_log[3]), 64'h01000111);
            check("t1_w4", 64'(m_log[4]), 64'h02000222);
            check("t1_w5", 64'(m_log[5]), 64'h03000333);
        end

        // marker mismatch sets flag bit 0
        do_reset();
        burst(32'h12345678, 32'd500, 24'h000111, 24'h000222, 24'h000333, 24'h004445, 10);
        check("t2_count", 64'(m_log.size()), 64'd6);
        if (m_log.size() == 6) begin
            check("t2_w0", 64'(m_log[0]), 64'hA5000106);
            check("t2_w5", 64'(m_log[5]), 64'h03000333);
        end

        // stalled consumer, three bursts at 6-cycle period: two dropped
        do_reset();
        pk_rdy = 0;
        for (int i = 0; i < 3; i++)
            burst(32'h100 + i, 32'h200 + i, 24'h1, 24'h2, 24'h3, 24'h004444, 2);
        idle(6);
        check("t3_level", 64'(fifo_level), 64'd6);
        pk_rdy = 1;
        idle(8);
        burst(32'h400, 32'h500, 24'h4, 24'h5, 24'h6, 24'h004444, 10);
        check("t3_count", 64'(m_log.size()), 64'd12);
        if (m_log.size() == 12) begin
            check("t3_seq0", 64'(m_log[0]), 64'hA5000006);
            check("t3_seq3", 64'(m_log[6]), 64'hA5030006);
        end

        // truncated burst leaves seq unchanged
        do_reset();
        dp_vld = 1; dp_data = 24'hAAA; step();
        dp_data = 24'hBBB; step();
        idle(3);
        check("t4_level", 64'(fifo_level), 64'd0);
        burst(32'h7, 32'h8, 24'h9, 24'hA, 24'hB, 24'h004444, 10);
        check("t4_count", 64'(m_log.size()), 64'd6);
        if (m_log.size() == 6) check("t4_w0", 64'(m_log[0]), 64'hA5000006);

        // consumer ready toggling every cycle over four frames
        do_reset();
        tog_mode = 1;
        for (int i = 0; i < 4; i++)
            burst($urandom, $urandom, 24'($urandom), 24'($urandom), 24'($urandom), 24'h004444, 10);
        idle(16);
        tog_mode = 0;
        pk_rdy = 1;
        idle(2);
        check("t5_count", 64'(m_log.size()), 64'd24);
        if (m_log.size() == 24) begin
            for (int f = 0; f < 4; f++)
                check("t5_hdr", 64'(m_log[6*f]), 64'({8'hA5, 8'(f), 16'h0006}));
        end

        // reset in the middle of the writer
        do_reset();
        pk_rdy = 0;
        burst(32'h11, 32'h22, 24'h33, 24'h44, 24'h55, 24'h004444, 2);
        rst = 1; step();
        rst = 0;
        check("t6_level", 64'(fifo_level), 64'd0);
        check("t6_vld", 64'(pk_vld), 64'd0);
        pk_rdy = 1;
        m_log.delete();
        burst(32'h66, 32'h77, 24'h88, 24'h99, 24'hAA, 24'h004444, 10);
        check("t6_count", 64'(m_log.size()), 64'd6);
        if (m_log.size() == 6) check("t6_w0", 64'(m_log[0]), 64'hA5000006);

        // randomized legal stream: full and truncated bursts with random backpressure
        do_reset();
        for (int b = 0; b < 120; b++) begin
            r1 = $urandom;
            r2 = $urandom;
            pk_rdy = r2[0] | r2[1];
            if (r1[3:0] == 0) begin
                len = 1 + int'($urandom_range(2));
                dp_utc = $urandom; dp_ns = $urandom;
                for (int k = 0; k < len; k++) begin
                    dp_vld = 1; dp_data = 24'($urandom); step();
                end
                idle(1 + int'($urandom_range(3)));
            end else begin
                burst($urandom, $urandom, 24'($urandom), 24'($urandom), 24'($urandom),
                      (r1[5:4] == 0) ? 24'($urandom) : 24'h004444,
                      2 + int'($urandom_range(6)));
            end
        end
        pk_rdy = 1;
        idle(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
